mem_port_arbiter: RTL and testbench

//  Shares the single-port instruction/data memory between the fetch requester (IF) and the

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_starve_cnt.sv | 37 +++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_I = 2'd1,
        ARB_OWN_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Fetch starvation counter: counts denied fetch cycles, saturates, clears on a fetch grant,
// and flags when fetch must be allowed to win the next arbitration.
module arb_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic gnt_i,
    output logic starve_o
);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_i) begin
            cnt_d = '0;
        end else if (req_i && (cnt_q != {STARVE_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Registered count only, so the fetch grant never loops back combinationally.
    assign starve_o = (int'(cnt_q) >= STARVE_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data requesters, one access in flight.
// Define ARB_STARVE_GUARD_EN to build the fetch starvation guard; otherwise data always wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    arb_state_e state_q, state_d;
    logic       resp_i, resp_d;
    logic       arb_en, pick_i, pick_d;
    logic       starve_hit;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (if_req_i),
        .gnt_i    (if_gnt_o),
        .starve_o (starve_hit)
    );
`else
    assign starve_hit = 1'b0;
`endif

    // A response is only meaningful while a port owns the memory; stray ones in IDLE drop out.
    assign resp_i = (state_q == ARB_OWN_I) && mem_rvalid_i;
    assign resp_d = (state_q == ARB_OWN_D) && mem_rvalid_i;

    // rst_i gating keeps every output low while reset is held, even with requests present.
    assign arb_en = rst_i && ((state_q == ARB_IDLE) || resp_i || resp_d);
    assign pick_i = arb_en && if_req_i && (starve_hit || !d_req_i);
    assign pick_d = arb_en && d_req_i && !pick_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_d)      state_d = ARB_OWN_D;
                else if (pick_i) state_d = ARB_OWN_I;
            end
            ARB_OWN_I, ARB_OWN_D: begin
                if (resp_i || resp_d) begin
                    if (pick_d)      state_d = ARB_OWN_D;
                    else if (pick_i) state_d = ARB_OWN_I;
                    else             state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o    = pick_i;
        d_gnt_o     = pick_d;
        mem_req_o   = pick_i || pick_d;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (pick_d) begin
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_be_i;
        end else if (pick_i) begin
            mem_addr_o  = if_addr_i;
            mem_be_o    = '1;
        end
        if_rvalid_o = resp_i;
        d_rvalid_o  = resp_d;
        if_rdata_o  = resp_i ? mem_rdata_i : '0;
        d_rdata_o   = resp_d ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected read data into per-port
// queues, a monitor pops them on each response strobe; a small memory model answers accesses.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];

    logic        mem_en = 1'b1;
    logic        stray  = 1'b0;
    logic        pend   = 1'b0;
    logic        pwe    = 1'b0;
    logic [31:0] paddr  = '0;

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // One-cycle memory: answers the cycle after mem_req_o; stores return zero data.
    always @(posedge clk_i) begin
        pend  <= mem_req_o & mem_en;
        paddr <= mem_addr_o;
        pwe   <= mem_we_o;
    end
    assign mem_rvalid_i = pend | stray;
    assign mem_rdata_i  = pend ? (pwe ? 32'h0 : rd(paddr)) : (stray ? 32'h1234_5678 : 32'h0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        #2;
        if (if_rvalid_o) begin
            if (if_q.size() == 0) chk("if_unexpected_rvalid", 1, 0);
            else chk("if_rdata", {32'h0, if_rdata_o}, {32'h0, if_q.pop_front()});
        end else chk("if_rdata_idle", {32'h0, if_rdata_o}, 64'h0);
        if (d_rvalid_o) begin
            if (d_q.size() == 0) chk("d_unexpected_rvalid", 1, 0);
            else chk("d_rdata", {32'h0, d_rdata_o}, {32'h0, d_q.pop_front()});
        end else chk("d_rdata_idle", {32'h0, d_rdata_o}, 64'h0);
    end

    task automatic idle_inputs();
        if_req_i = 0; if_addr_i = '0;
        d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    endtask

    task automatic chk_grant(input string name, input logic ig, input logic dg,
                             input logic mr, input logic [31:0] ma);
        chk({name, "_if_gnt"}, {63'h0, if_gnt_o}, {63'h0, ig});
        chk({name, "_d_gnt"}, {63'h0, d_gnt_o}, {63'h0, dg});
        chk({name, "_mem_req"}, {63'h0, mem_req_o}, {63'h0, mr});
        if (mr) chk({name, "_mem_addr"}, {32'h0, mem_addr_o}, {32'h0, ma});
    endtask

    // Grant order under a continuous data load plus a continuous fetch.
`ifdef ARB_STARVE_GUARD_EN
    logic [5:0] starve_exp = 6'b010000;   // bit k = fetch wins cycle k
`else
    logic [5:0] starve_exp = 6'b000000;
`endif

    logic [31:0] faddr[3] = '{32'h0, 32'h4, 32'h8};

    initial begin
        idle_inputs();
        rst_i = 0;

        // Reset held 3 cycles with a data request already pending.
        d_req_i = 1; d_addr_i = 32'h80;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); #2;
            chk("reset_outputs",
                {45'h0, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o,
                 mem_be_o, if_rdata_o[7:0] | d_rdata_o[7:0] | mem_addr_o[7:0] | mem_wdata_o[7:0]},
                64'h0);
        end
        @(negedge clk_i); rst_i = 1; #2;
        chk_grant("reset_release", 0, 1, 1, 32'h80);
        d_q.push_back(rd(32'h80));
        @(negedge clk_i); idle_inputs(); #2;
        chk_grant("reset_release_resp", 0, 0, 0, 0);

        // Fetch-only stream: request, response, request ...
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); if_req_i = 1; if_addr_i = faddr[i]; #2;
            chk_grant("fetch_gnt", 1, 0, 1, faddr[i]);
            chk("fetch_we_be", {59'h0, mem_we_o, mem_be_o}, {59'h0, 1'b0, 4'hF});
            if_q.push_back(rd(faddr[i]));
            @(negedge clk_i); if_req_i = 0; #2;
            chk_grant("fetch_resp", 0, 0, 0, 0);
            chk("fetch_rvalid", {62'h0, if_rvalid_o, d_rvalid_o}, {62'h0, 2'b10});
        end

        // Simultaneous requests in IDLE: data first, fetch in the data response cycle.
        @(negedge clk_i);
        if_req_i = 1; if_addr_i = 32'h10; d_req_i = 1; d_addr_i = 32'h100; #2;
        chk_grant("simul_first", 0, 1, 1, 32'h100);
        d_q.push_back(rd(32'h100));
        @(negedge clk_i); d_req_i = 0; #2;
        chk("simul_d_rvalid", {63'h0, d_rvalid_o}, 64'h1);
        chk_grant("simul_second", 1, 0, 1, 32'h10);
        if_q.push_back(rd(32'h10));
        @(negedge clk_i); idle_inputs(); #2;
        chk("simul_if_rvalid", {63'h0, if_rvalid_o}, 64'h1);
        chk_grant("simul_done", 0, 0, 0, 0);

        // Store with partial byte enables.
        @(negedge clk_i);
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011; #2;
        chk_grant("store_gnt", 0, 1, 1, 32'h200);
        chk("store_we_be", {59'h0, mem_we_o, mem_be_o}, {59'h0, 1'b1, 4'b0011});
        chk("store_wdata", {32'h0, mem_wdata_o}, {32'h0, 32'hDEAD_BEEF});
        d_q.push_back(32'h0);
        @(negedge clk_i); idle_inputs(); #2;
        chk("store_ack", {62'h0, if_rvalid_o, d_rvalid_o}, {62'h0, 2'b01});

        // Continuous data load against continuous fetch.
        @(negedge clk_i);
        d_req_i = 1; d_addr_i = 32'h300; if_req_i = 1; if_addr_i = 32'h40;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk_i);
            #2;
            if (starve_exp[k]) begin
                chk_grant("starve_cycle", 1, 0, 1, 32'h40);
                if_q.push_back(rd(32'h40));
            end else begin
                chk_grant("starve_cycle", 0, 1, 1, 32'h300);
                d_q.push_back(rd(32'h300));
            end
        end
        @(negedge clk_i); idle_inputs(); #2;
        chk_grant("starve_drain", 0, 0, 0, 0);

        // Reset in the middle of an outstanding data access, then a late response.
        @(negedge clk_i); mem_en = 0; d_req_i = 1; d_addr_i = 32'h400; #2;
        chk_grant("abort_gnt", 0, 1, 1, 32'h400);
        @(negedge clk_i); idle_inputs(); #2;
        chk_grant("abort_own", 0, 0, 0, 0);
        #1 rst_i = 0; #1;
        chk("abort_in_reset", {62'h0, d_rvalid_o, mem_req_o}, 64'h0);
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1; mem_en = 1; stray = 1; #2;
        chk("late_resp_ignored", {62'h0, if_rvalid_o, d_rvalid_o}, 64'h0);
        @(negedge clk_i); stray = 0; d_req_i = 1; d_addr_i = 32'h500; #2;
        chk_grant("post_abort_gnt", 0, 1, 1, 32'h500);
        d_q.push_back(rd(32'h500));
        @(negedge clk_i); idle_inputs(); #2;
        chk("post_abort_resp", {63'h0, d_rvalid_o}, 64'h1);

        @(negedge clk_i); @(negedge clk_i); #3;
        chk("if_queue_drained", 64'(if_q.size()), 64'h0);
        chk("d_queue_drained", 64'(d_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
